// File: rtl/m72_pkg.sv
// m72_pkg: shared types for the M72 sound subsystem (sample-fetch FSM states,
// sample-ROM location in SDRAM, and the little-endian byte picker).
package m72_pkg;

  typedef enum logic [1:0] {SF_IDLE, SF_REQ, SF_DROP} sample_fetch_state_t;

  localparam logic [24:0] SAMPLE_ROM_BASE = 25'h0180000;

  function automatic logic [7:0] sample_byte(input logic [15:0] word, input logic odd);
    return odd ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/sample_fetch_ctrl.sv
// sample_fetch_ctrl: Z80 sample-address counter (ports 80h/81h/82h) and SDRAM byte fetcher
// feeding port 84h. Define SAMPLE_PREFETCH_EN for the word buffer with next-word prefetch.
module sample_fetch_ctrl
  import m72_pkg::*;
#(
  parameter int                SDR_AW    = 25,
  parameter logic [SDR_AW-1:0] BASE_ADDR = SDR_AW'(SAMPLE_ROM_BASE)
) (
  input  logic              CLK_32M,
  input  logic              reset_n,
  input  logic              pause,
  input  logic [15:0]       sample_addr,
  input  logic [1:0]        sample_addr_wr,
  input  logic              sample_inc,
  output logic [7:0]        sample_data,
  output logic              sample_valid,
  output logic              rom_req,
  output logic [SDR_AW-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [15:0]       rom_data
);

  sample_fetch_state_t state;
  logic [15:0] addr_q, addr_new, addr_nxt;
  logic        chg, hit, valid_eff, stale, take_data;
  logic        idle_free, issue_dem, issue_bg, issue;
  logic [14:0] issue_word;
  logic [7:0]  ack_byte, buf_byte;

  // Load beats increment; a strobe only counts when not paused.
  always_comb begin
    addr_new = addr_q;
    if (sample_addr_wr[0]) addr_new[7:0]  = sample_addr[7:0];
    if (sample_addr_wr[1]) addr_new[15:8] = sample_addr[15:8];
    if (sample_addr_wr == 2'b00 && sample_inc) addr_new = addr_q + 16'd1;
  end

  assign chg       = !pause && (sample_addr_wr != 2'b00 || sample_inc);
  assign addr_nxt  = chg ? addr_new : addr_q;
  assign valid_eff = chg ? hit : sample_valid;
  assign idle_free = (state != SF_REQ) && !pause;
  assign issue_dem = idle_free && !valid_eff;
  assign issue     = issue_dem || issue_bg;
  assign issue_word = issue_dem ? addr_nxt[15:1] : addr_nxt[15:1] + 15'd1;
  assign ack_byte  = sample_byte(rom_data, addr_nxt[0]);

`ifdef SAMPLE_PREFETCH_EN
  logic [14:0] buf_word, req_word;
  logic [15:0] buf_data;
  logic        buf_ok, ack_take;

  assign ack_take  = (state == SF_REQ) && rom_ack;
  assign hit       = buf_ok && (buf_word == addr_nxt[15:1]);
  assign buf_byte  = sample_byte(buf_data, addr_nxt[0]);
  assign take_data = (req_word == addr_nxt[15:1]);
  // Sitting on the odd byte of a word: pull the following word in the background.
  assign issue_bg  = idle_free && valid_eff && addr_nxt[0] &&
                     !(buf_ok && buf_word == addr_nxt[15:1] + 15'd1);

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n)      buf_ok <= 1'b0;
    else if (ack_take) buf_ok <= 1'b1;
  end

  always_ff @(posedge CLK_32M) begin
    if (issue) req_word <= issue_word;
    if (ack_take) begin
      buf_word <= req_word;
      buf_data <= rom_data;
    end
  end
`else
  assign hit       = 1'b0;
  assign buf_byte  = 8'h00;
  assign take_data = !(stale || chg);
  assign issue_bg  = 1'b0;
`endif

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      state        <= SF_IDLE;
      addr_q       <= 16'h0000;
      sample_data  <= 8'h00;
      sample_valid <= 1'b0;
      rom_req      <= 1'b0;
      stale        <= 1'b0;
    end else begin
      addr_q <= addr_nxt;
      if (chg) begin
        sample_valid <= hit;
        if (hit) sample_data <= buf_byte;
      end
      case (state)
        SF_IDLE, SF_DROP: begin
          if (issue) begin
            state   <= SF_REQ;
            rom_req <= 1'b1;
            stale   <= 1'b0;
          end else begin
            state <= SF_IDLE;
          end
        end
        SF_REQ: begin
          if (rom_ack) begin
            rom_req <= 1'b0;
            if (take_data) begin
              sample_data  <= ack_byte;
              sample_valid <= 1'b1;
              state        <= SF_IDLE;
            end else begin
              // Stale data: request drops for a cycle before the refetch.
              state <= (stale || chg) ? SF_DROP : SF_IDLE;
            end
          end else if (chg) begin
            stale <= 1'b1;
          end
        end
        default: state <= SF_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_32M) begin
    if (issue) rom_addr <= BASE_ADDR + {{(SDR_AW-16){1'b0}}, issue_word, 1'b0};
  end

endmodule

// File: tb/tb_sample_fetch_ctrl.sv
// tb_sample_fetch_ctrl: directed scenarios plus randomized strobes/acks, checked every cycle
// against a transaction-level model of the sample fetcher.
module tb_sample_fetch_ctrl;

  localparam int BASE = 'h180000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] sample_addr = 16'h0000;
  logic [1:0]  sample_addr_wr = 2'b00;
  logic        sample_inc = 1'b0;
  logic [7:0]  sample_data;
  logic        sample_valid;
  logic        rom_req;
  logic [24:0] rom_addr;
  logic        rom_ack = 1'b0;
  logic [15:0] rom_data = 16'h0000;

  int vectors = 0;
  int miscompares = 0;
  bit auto_ack = 1'b0;
  int ack_wait = 0;

  sample_fetch_ctrl dut (
    .CLK_32M(clk), .reset_n(reset_n), .pause(pause),
    .sample_addr(sample_addr), .sample_addr_wr(sample_addr_wr), .sample_inc(sample_inc),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, want 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: current address, whether the presented byte belongs to it, and the one
  // outstanding request (its address and whether the address moved since it went out).
  int m_addr = 0, m_req_addr = 0, m_data = 0, na = 0;
  bit m_valid = 0, m_busy = 0, m_dirty = 0, acc = 0, was_busy = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_addr = 0; m_valid = 0; m_data = 0; m_busy = 0; m_dirty = 0;
    end else begin
      acc = !pause && (sample_addr_wr != 2'b00 || sample_inc);
      na = m_addr;
      if (sample_addr_wr[0]) na = (na / 256) * 256 + sample_addr % 256;
      if (sample_addr_wr[1]) na = (sample_addr / 256) * 256 + na % 256;
      if (sample_addr_wr == 2'b00 && sample_inc) na = (na + 1) % 65536;
      was_busy = m_busy;
      if (acc) begin
        m_addr = na;
        m_valid = 0;
      end
      if (was_busy) begin
        if (rom_ack) begin
          m_busy = 0;
          if (!m_dirty && !acc) begin
            m_valid = 1;
            m_data = (m_addr % 2 == 1) ? rom_data / 256 : rom_data % 256;
          end
        end else if (acc) begin
          m_dirty = 1;
        end
      end else if (!pause && !m_valid) begin
        m_busy = 1;
        m_dirty = 0;
        m_req_addr = BASE + (m_addr / 2) * 2;
      end
    end
  end

`ifndef SAMPLE_PREFETCH_EN
  always @(negedge clk) begin
    chk("rom_req", rom_req, m_busy);
    chk("sample_valid", sample_valid, m_valid);
    chk("sample_data", sample_data, m_data);
    if (m_busy) chk("rom_addr", rom_addr, m_req_addr);
  end
`endif

  task automatic cycle();
    @(negedge clk);
    rom_ack = 1'b0;
    if (auto_ack) begin
      if (!rom_req) ack_wait = $urandom_range(0, 5);
      else if (ack_wait == 0) begin
        rom_ack = 1'b1;
        rom_data = 16'($urandom);
        ack_wait = $urandom_range(0, 5);
      end else ack_wait--;
    end
  endtask

  task automatic load(input logic [15:0] a);
    sample_addr = a;
    sample_addr_wr = 2'b11;
    cycle();
    sample_addr_wr = 2'b00;
  endtask

  task automatic ack(input logic [15:0] d);
    rom_ack = 1'b1;
    rom_data = d;
    cycle();
  endtask

  task automatic wait_req();
    int n = 0;
    while (!rom_req && n < 20) begin
      cycle();
      n++;
    end
    chk("req_rise", rom_req, 1);
  endtask

  task automatic strobe_inc();
    sample_inc = 1'b1;
    cycle();
    sample_inc = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) cycle();
    chk("rst_req", rom_req, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_data", sample_data, 8'h00);
    reset_n = 1'b1;

    // 1: first fetch after reset is address 0
    cycle();
    chk("t1_req", rom_req, 1);
    chk("t1_addr", rom_addr, 25'h0180000);
    repeat (4) cycle();
    ack(16'hA55A);
    chk("t1_data", sample_data, 8'h5A);
    chk("t1_valid", sample_valid, 1);

    // 2: full load of an odd address picks the high byte
    cycle();
    load(16'h1235);
    chk("t2_req", rom_req, 1);
    chk("t2_addr", rom_addr, 25'h0181234);
    ack(16'hBEEF);
    chk("t2_data", sample_data, 8'hBE);
    chk("t2_valid", sample_valid, 1);

`ifndef SAMPLE_PREFETCH_EN
    // 3: increment wraps FFFF -> 0000
    load(16'hFFFF);
    wait_req();
    ack(16'h0000);
    strobe_inc();
    chk("t3_req", rom_req, 1);
    chk("t3_addr", rom_addr, 25'h0180000);

    // 4: increment during an outstanding request discards the first ack
    cycle();
    cycle();
    strobe_inc();
    chk("t4_req_held", rom_req, 1);
    ack(16'h1234);
    chk("t4_req_drop", rom_req, 0);
    chk("t4_valid_low", sample_valid, 0);
    cycle();
    chk("t4_refetch", rom_req, 1);
    chk("t4_addr", rom_addr, 25'h0180000);
    ack(16'h7788);
    chk("t4_data", sample_data, 8'h77);
    chk("t4_valid", sample_valid, 1);

    // 5: low-byte load with a simultaneous increment: load wins
    load(16'h12FF);
    wait_req();
    ack(16'h0000);
    sample_addr = 16'hAB40;
    sample_addr_wr = 2'b01;
    sample_inc = 1'b1;
    cycle();
    sample_addr_wr = 2'b00;
    sample_inc = 1'b0;
    chk("t5_addr", rom_addr, 25'h0181240);
    ack(16'h3344);
    chk("t5_data", sample_data, 8'h44);
`endif

    // 6: increment within a fetched word
    load(16'h0010);
    n = 0;
    while (!sample_valid && n < 4) begin
      wait_req();
      ack(16'h2211);
      n++;
    end
    chk("t6_data0", sample_data, 8'h11);
    strobe_inc();
`ifdef SAMPLE_PREFETCH_EN
    chk("t6_req", rom_req, 0);
    chk("t6_valid", sample_valid, 1);
    chk("t6_data1", sample_data, 8'h22);
`else
    chk("t6_req", rom_req, 1);
    chk("t6_valid", sample_valid, 0);
`endif

    // Randomized traffic with a responder acking after 0-5 cycles
    auto_ack = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1700) begin
        @(posedge clk);
        #2 reset_n = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b1;
      end
      cycle();
      sample_addr = ($urandom % 40 == 0) ? 16'hFFFF : 16'($urandom);
      if ((i / 500) % 2 == 0) begin
        sample_addr_wr = ($urandom % 6 == 0) ? 2'($urandom) : 2'b00;
        sample_inc = ($urandom % 5 == 0);
      end else begin
        sample_addr_wr = ($urandom % 40 == 0) ? 2'($urandom) : 2'b00;
        sample_inc = ($urandom % 12 == 0);
      end
      pause = ($urandom % 7 == 0);
    end
    sample_addr_wr = 2'b00;
    sample_inc = 1'b0;
    pause = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
